// File: rtl/ins_dispatch_sb_if.sv
// Instruction-stream and engine-port bundle for the instruction dispatcher.
// master = instruction source / engine side, slave = dispatcher side.
interface ins_dispatch_sb_if #(
    parameter int unsigned INST_W = 64
) ();
    logic              ins_valid;
    logic              ins_ready;
    logic [INST_W-1:0] ins;

    logic              ld_ins_valid;
    logic              ld_ins_ready;
    logic [INST_W-1:0] ld_ins;

    logic              pe_ins_valid;
    logic              pe_ins_ready;
    logic [INST_W-1:0] pe_ins;

    logic              st_ins_valid;
    logic              st_ins_ready;
    logic [INST_W-1:0] st_ins;

    modport master (
        output ins_valid, ins,
        input  ins_ready,
        input  ld_ins_valid, ld_ins,
        output ld_ins_ready,
        input  pe_ins_valid, pe_ins,
        output pe_ins_ready,
        input  st_ins_valid, st_ins,
        output st_ins_ready
    );

    modport slave (
        input  ins_valid, ins,
        output ins_ready,
        output ld_ins_valid, ld_ins,
        input  ld_ins_ready,
        output pe_ins_valid, pe_ins,
        input  pe_ins_ready,
        output st_ins_valid, st_ins,
        input  st_ins_ready
    );
endinterface

// File: rtl/ins_dispatch_sb.sv
// Instruction dispatcher with per-class queues and a load/compute scoreboard:
// compute issues only once its buffer slot is loaded and the PE array is idle.
module ins_dispatch_sb #(
    parameter int unsigned INST_W  = 64,
    parameter int unsigned PE_NUM  = 32,
    parameter int unsigned Q_DEPTH = 4,
    parameter int unsigned BUF_NUM = 2
) (
    input  logic              clk,
    input  logic              rst,
    ins_dispatch_sb_if.slave  bus,
    input  logic              rx_done_pulse,
    input  logic [5:0]        rx_done_buf_id,
    input  logic [PE_NUM-1:0] pe_done,
    output logic [3:0]        conf_layer_type,
    output logic [3:0]        conf_in_ch_seg,
    output logic [3:0]        conf_out_ch_seg,
    output logic [7:0]        conf_in_img_width,
    output logic [7:0]        conf_out_img_width,
    output logic              conf_pooling,
    output logic              conf_relu,
    output logic              conf_depool,
    output logic              working,
    output logic              err_illegal
);
    localparam int unsigned SLOT_W = $clog2(BUF_NUM);
    localparam int unsigned PTR_W  = $clog2(Q_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OUT_W  = $clog2(Q_DEPTH * BUF_NUM) + 1;

    localparam logic [3:0] ClsCfg = 4'd0;
    localparam logic [3:0] ClsLd  = 4'd1;
    localparam logic [3:0] ClsPe  = 4'd2;
    localparam logic [3:0] ClsSt  = 4'd3;

    // Queue index 0 = load, 1 = compute, 2 = store.
    logic [INST_W-1:0] mem_q [3][Q_DEPTH];
    logic [CNT_W-1:0]  wr_ptr_q [3];
    logic [CNT_W-1:0]  rd_ptr_q [3];
    logic [CNT_W-1:0]  q_fill [3];
    logic [2:0]        q_empty;
    logic [2:0]        q_full;
    logic [2:0]        q_push;
    logic [2:0]        q_pop;

    logic [OUT_W-1:0]  outst_q;
    logic [BUF_NUM-1:0] loaded_q;
    logic [BUF_NUM-1:0] loaded_d;
    logic              busy_q;
    logic              pe_done_all_q;
    logic              working_q;
    logic              err_q;

    logic [3:0]        conf_layer_type_q;
    logic [3:0]        conf_in_ch_seg_q;
    logic [3:0]        conf_out_ch_seg_q;
    logic [7:0]        conf_in_img_width_q;
    logic [7:0]        conf_out_img_width_q;
    logic              conf_pooling_q;
    logic              conf_relu_q;
    logic              conf_depool_q;

    logic [3:0]        ins_cls;
    logic              ins_ready_c;
    logic              ins_acc;
    logic              cfg_acc;
    logic              ill_acc;
    logic [INST_W-1:0] ld_head;
    logic [INST_W-1:0] pe_head;
    logic [INST_W-1:0] st_head;
    logic [SLOT_W-1:0] pe_slot;
    logic [SLOT_W-1:0] rx_slot;
    logic              rx_ok;
    logic              pe_rise;
    logic              pe_valid_c;
    logic              st_valid_c;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            q_fill[i]  = wr_ptr_q[i] - rd_ptr_q[i];
            q_empty[i] = (q_fill[i] == '0);
            q_full[i]  = (q_fill[i] == CNT_W'(Q_DEPTH));
        end
    end

    assign ins_cls = bus.ins[INST_W-1 -: 4];

    // Config waits for full drain so layer parameters never change under in-flight work.
    always_comb begin
        ins_ready_c = 1'b1;
        unique case (ins_cls)
            ClsCfg:  ins_ready_c = (&q_empty) && (outst_q == '0) && !busy_q;
            ClsLd:   ins_ready_c = !q_full[0];
            ClsPe:   ins_ready_c = !q_full[1];
            ClsSt:   ins_ready_c = !q_full[2];
            default: ins_ready_c = 1'b1;
        endcase
    end

    assign ins_acc   = bus.ins_valid && ins_ready_c;
    assign cfg_acc   = ins_acc && (ins_cls == ClsCfg);
    assign ill_acc   = ins_acc && (ins_cls[3:2] != 2'b00);
    assign q_push[0] = ins_acc && (ins_cls == ClsLd);
    assign q_push[1] = ins_acc && (ins_cls == ClsPe);
    assign q_push[2] = ins_acc && (ins_cls == ClsSt);

    assign ld_head = mem_q[0][rd_ptr_q[0][PTR_W-1:0]];
    assign pe_head = mem_q[1][rd_ptr_q[1][PTR_W-1:0]];
    assign st_head = mem_q[2][rd_ptr_q[2][PTR_W-1:0]];
    assign pe_slot = pe_head[SLOT_W-1:0];
    assign rx_slot = rx_done_buf_id[SLOT_W-1:0];

    assign pe_valid_c = !q_empty[1] && loaded_q[pe_slot] && !busy_q;
    assign st_valid_c = !q_empty[2] && q_empty[1] && !busy_q;

    assign q_pop[0] = !q_empty[0] && bus.ld_ins_ready;
    assign q_pop[1] = pe_valid_c && bus.pe_ins_ready;
    assign q_pop[2] = st_valid_c && bus.st_ins_ready;

    assign rx_ok   = rx_done_pulse && (outst_q != '0);
    assign pe_rise = (&pe_done) && !pe_done_all_q;

    // A completion landing on the slot being consumed re-marks it loaded.
    always_comb begin
        loaded_d = loaded_q;
        if (q_pop[1]) loaded_d[pe_slot] = 1'b0;
        if (rx_ok)    loaded_d[rx_slot] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (q_push[i]) mem_q[i][wr_ptr_q[i][PTR_W-1:0]] <= bus.ins;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            outst_q              <= '0;
            loaded_q             <= '0;
            busy_q               <= 1'b0;
            pe_done_all_q        <= 1'b1;
            working_q            <= 1'b0;
            err_q                <= 1'b0;
            conf_layer_type_q    <= '0;
            conf_in_ch_seg_q     <= '0;
            conf_out_ch_seg_q    <= '0;
            conf_in_img_width_q  <= '0;
            conf_out_img_width_q <= '0;
            conf_pooling_q       <= 1'b0;
            conf_relu_q          <= 1'b0;
            conf_depool_q        <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (q_push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (q_pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            end
            if (q_pop[0] && !rx_ok) begin
                outst_q <= outst_q + 1'b1;
            end else if (!q_pop[0] && rx_ok) begin
                outst_q <= outst_q - 1'b1;
            end
            loaded_q      <= loaded_d;
            pe_done_all_q <= &pe_done;
            if (pe_rise)  busy_q <= 1'b0;
            if (q_pop[1]) busy_q <= 1'b1;
            if (ill_acc)  err_q <= 1'b1;
            working_q <= !(&q_empty) || (outst_q != '0) || busy_q;
            if (cfg_acc) begin
                conf_layer_type_q    <= bus.ins[59:56];
                conf_in_ch_seg_q     <= bus.ins[55:52];
                conf_out_ch_seg_q    <= bus.ins[51:48];
                conf_in_img_width_q  <= bus.ins[47:40];
                conf_out_img_width_q <= bus.ins[39:32];
                conf_pooling_q       <= bus.ins[2];
                conf_relu_q          <= bus.ins[1];
                conf_depool_q        <= bus.ins[0];
            end
        end
    end

    assign bus.ins_ready    = ins_ready_c;
    assign bus.ld_ins_valid = !q_empty[0];
    assign bus.ld_ins       = ld_head;
    assign bus.pe_ins_valid = pe_valid_c;
    assign bus.pe_ins       = pe_head;
    assign bus.st_ins_valid = st_valid_c;
    assign bus.st_ins       = st_head;

    assign conf_layer_type    = conf_layer_type_q;
    assign conf_in_ch_seg     = conf_in_ch_seg_q;
    assign conf_out_ch_seg    = conf_out_ch_seg_q;
    assign conf_in_img_width  = conf_in_img_width_q;
    assign conf_out_img_width = conf_out_img_width_q;
    assign conf_pooling       = conf_pooling_q;
    assign conf_relu          = conf_relu_q;
    assign conf_depool        = conf_depool_q;
    assign working            = working_q;
    assign err_illegal        = err_q;

    logic unused_bits;
    assign unused_bits = ^{rx_done_buf_id, bus.ins, ld_head, pe_head};
endmodule

// File: tb/tb_ins_dispatch_sb.sv
// Directed bench for ins_dispatch_sb: scoreboard gating, busy edge detection,
// queue backpressure, config drain, illegal opcodes and reset.
module tb_ins_dispatch_sb;
    localparam int unsigned INST_W  = 64;
    localparam int unsigned PE_NUM  = 32;
    localparam int unsigned Q_DEPTH = 4;
    localparam int unsigned BUF_NUM = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_done_pulse;
    logic [5:0]        rx_done_buf_id;
    logic [PE_NUM-1:0] pe_done;
    logic [3:0]        conf_layer_type, conf_in_ch_seg, conf_out_ch_seg;
    logic [7:0]        conf_in_img_width, conf_out_img_width;
    logic              conf_pooling, conf_relu, conf_depool;
    logic              working, err_illegal;

    int vecs  = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ins_dispatch_sb_if #(.INST_W(INST_W)) bus ();

    ins_dispatch_sb #(
        .INST_W (INST_W),
        .PE_NUM (PE_NUM),
        .Q_DEPTH(Q_DEPTH),
        .BUF_NUM(BUF_NUM)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .rx_done_pulse     (rx_done_pulse),
        .rx_done_buf_id    (rx_done_buf_id),
        .pe_done           (pe_done),
        .conf_layer_type   (conf_layer_type),
        .conf_in_ch_seg    (conf_in_ch_seg),
        .conf_out_ch_seg   (conf_out_ch_seg),
        .conf_in_img_width (conf_in_img_width),
        .conf_out_img_width(conf_out_img_width),
        .conf_pooling      (conf_pooling),
        .conf_relu         (conf_relu),
        .conf_depool       (conf_depool),
        .working           (working),
        .err_illegal       (err_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Probe the config-class ready term without offering an instruction.
    task automatic cfg_ready(input string tag, input logic exp);
        bus.ins_valid = 1'b0;
        bus.ins       = '0;
        #1;
        chk(tag, 64'(bus.ins_ready), 64'(exp));
    endtask

    function automatic logic [63:0] mk(input logic [3:0] c, input logic [59:0] body);
        return {c, body};
    endfunction

    logic [63:0] l1, c1, s1, cfg, ill, l6, l7, c0, s2, l8;
    logic [63:0] lq [5];

    initial begin
        l1  = mk(4'h1, 60'h123_4567_89AB_C001);
        c1  = mk(4'h2, 60'hFED_CBA9_8765_4001);
        s1  = mk(4'h3, 60'h0AA_55AA_55AA_5502);
        cfg = 64'h0356_A53C_0000_0005;
        ill = 64'h9000_0000_0000_0001;
        l6  = mk(4'h1, 60'h066_0000_0000_0000);
        l7  = mk(4'h1, 60'h077_0000_0000_0000);
        c0  = mk(4'h2, 60'h0C0_0000_0000_0000);
        s2  = mk(4'h3, 60'h0D2_0000_0000_0000);
        l8  = mk(4'h1, 60'h088_0000_0000_0000);
        for (int i = 0; i < 5; i++) lq[i] = mk(4'h1, 60'h0F0_0000_0000_0000 + 60'(i * 16));

        rst = 1'b1;
        bus.ins_valid = 1'b0; bus.ins = '0;
        bus.ld_ins_ready = 1'b0; bus.pe_ins_ready = 1'b0; bus.st_ins_ready = 1'b0;
        rx_done_pulse = 1'b0; rx_done_buf_id = '0; pe_done = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_working", 64'(working), 64'd0);
        chk("rst_err", 64'(err_illegal), 64'd0);
        chk("rst_ld_valid", 64'(bus.ld_ins_valid), 64'd0);
        chk("rst_pe_valid", 64'(bus.pe_ins_valid), 64'd0);
        chk("rst_st_valid", 64'(bus.st_ins_valid), 64'd0);
        chk("rst_conf_layer", 64'(conf_layer_type), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        cfg_ready("idle_cfg_ready", 1'b1);

        // Compute waits for its slot to be loaded.
        @(negedge clk); bus.ins_valid = 1'b1; bus.ins = l1; #1;
        chk("ld_push_ready", 64'(bus.ins_ready), 64'd1);
        chk("ld_not_same_cycle", 64'(bus.ld_ins_valid), 64'd0);
        @(negedge clk); bus.ins = c1; bus.ld_ins_ready = 1'b1; #1;
        chk("ld_valid_next", 64'(bus.ld_ins_valid), 64'd1);
        chk("ld_ins_data", bus.ld_ins, l1);
        chk("pe_push_ready", 64'(bus.ins_ready), 64'd1);
        @(negedge clk); bus.ins_valid = 1'b0; bus.ld_ins_ready = 1'b0; #1;
        chk("ld_popped", 64'(bus.ld_ins_valid), 64'd0);
        chk("pe_wait_no_rx", 64'(bus.pe_ins_valid), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("pe_wait_no_rx_2", 64'(bus.pe_ins_valid), 64'd0);
        chk("working_busy", 64'(working), 64'd1);
        rx_done_pulse = 1'b1; rx_done_buf_id = 6'd1;
        @(negedge clk); rx_done_pulse = 1'b0; #1;
        chk("pe_valid_after_rx", 64'(bus.pe_ins_valid), 64'd1);
        chk("pe_ins_data", bus.pe_ins, c1);
        @(negedge clk); pe_done = '1; #1;
        chk("pe_ins_stable", bus.pe_ins, c1);

        // Busy must not clear on a done level that was high before issue.
        @(negedge clk); bus.pe_ins_ready = 1'b1; #1;
        chk("pe_valid_pre_issue", 64'(bus.pe_ins_valid), 64'd1);
        @(negedge clk); bus.pe_ins_ready = 1'b0;
        cfg_ready("busy_blocks_cfg", 1'b0);
        chk("pe_valid_after_issue", 64'(bus.pe_ins_valid), 64'd0);
        repeat (3) @(negedge clk);
        cfg_ready("busy_held_done_high", 1'b0);
        @(negedge clk); pe_done = '0;
        cfg_ready("busy_done_low", 1'b0);
        @(negedge clk); pe_done = '1;
        cfg_ready("busy_before_rise", 1'b0);
        @(negedge clk);
        cfg_ready("busy_cleared_rise", 1'b1);

        // Config waits for the pending store to drain.
        @(negedge clk); bus.ins_valid = 1'b1; bus.ins = s1; #1;
        chk("st_push_ready", 64'(bus.ins_ready), 64'd1);
        @(negedge clk); bus.ins = cfg; #1;
        chk("cfg_blocked_store", 64'(bus.ins_ready), 64'd0);
        chk("st_valid", 64'(bus.st_ins_valid), 64'd1);
        chk("st_ins_data", bus.st_ins, s1);
        chk("conf_before", 64'(conf_in_img_width), 64'd0);
        @(negedge clk); bus.st_ins_ready = 1'b1; #1;
        chk("cfg_blocked_2", 64'(bus.ins_ready), 64'd0);
        @(negedge clk); bus.st_ins_ready = 1'b0; #1;
        chk("cfg_ready_idle", 64'(bus.ins_ready), 64'd1);
        chk("st_drained", 64'(bus.st_ins_valid), 64'd0);
        @(negedge clk); bus.ins_valid = 1'b0; #1;
        chk("conf_in_img_width", 64'(conf_in_img_width), 64'hA5);
        chk("conf_out_img_width", 64'(conf_out_img_width), 64'h3C);
        chk("conf_layer_type", 64'(conf_layer_type), 64'h3);
        chk("conf_in_ch_seg", 64'(conf_in_ch_seg), 64'h5);
        chk("conf_out_ch_seg", 64'(conf_out_ch_seg), 64'h6);
        chk("conf_flags", 64'({conf_pooling, conf_relu, conf_depool}), 64'b101);

        // Illegal opcode is swallowed and flagged stickily.
        @(negedge clk); bus.ins_valid = 1'b1; bus.ins = ill; #1;
        chk("ill_ready", 64'(bus.ins_ready), 64'd1);
        @(negedge clk); bus.ins_valid = 1'b0; #1;
        chk("ill_err_set", 64'(err_illegal), 64'd1);
        chk("ill_no_valid",
            64'({bus.ld_ins_valid, bus.pe_ins_valid, bus.st_ins_valid}), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("ill_err_sticky", 64'(err_illegal), 64'd1);

        // Load queue backpressure and order.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); bus.ins_valid = 1'b1; bus.ins = lq[i]; #1;
            chk("ldq_fill_ready", 64'(bus.ins_ready), 64'd1);
        end
        @(negedge clk); bus.ins = lq[4]; #1;
        chk("ldq_full_5th", 64'(bus.ins_ready), 64'd0);
        @(negedge clk); bus.ins_valid = 1'b0; bus.ld_ins_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ldq_order_valid", 64'(bus.ld_ins_valid), 64'd1);
            chk("ldq_order_data", bus.ld_ins, lq[i]);
            @(negedge clk);
        end
        bus.ld_ins_ready = 1'b0; #1;
        chk("ldq_only_4", 64'(bus.ld_ins_valid), 64'd0);
        rx_done_pulse = 1'b1; rx_done_buf_id = 6'd0;
        repeat (4) @(negedge clk);
        rx_done_pulse = 1'b0;
        cfg_ready("outst_drained", 1'b1);

        // Load handshake and completion in the same cycle cancel out.
        @(negedge clk); bus.ins_valid = 1'b1; bus.ins = l6;
        @(negedge clk); bus.ins_valid = 1'b0; bus.ld_ins_ready = 1'b1;
        @(negedge clk); bus.ld_ins_ready = 1'b0; bus.ins_valid = 1'b1; bus.ins = l7;
        @(negedge clk); bus.ins_valid = 1'b0; bus.ld_ins_ready = 1'b1; rx_done_pulse = 1'b1;
        @(negedge clk); bus.ld_ins_ready = 1'b0; rx_done_pulse = 1'b0;
        cfg_ready("outst_stays_1", 1'b0);
        rx_done_pulse = 1'b1;
        @(negedge clk); rx_done_pulse = 1'b0;
        cfg_ready("outst_back_0", 1'b1);

        // Reset in the middle of traffic.
        @(negedge clk); bus.ins_valid = 1'b1; bus.ins = c0;
        @(negedge clk); bus.ins = s2;
        @(negedge clk); bus.ins = l8;
        @(negedge clk); bus.ins_valid = 1'b0; #1;
        chk("mid_pe_valid", 64'(bus.pe_ins_valid), 64'd1);
        chk("mid_st_gated", 64'(bus.st_ins_valid), 64'd0);
        chk("mid_ld_valid", 64'(bus.ld_ins_valid), 64'd1);
        chk("mid_working", 64'(working), 64'd1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("rst2_working", 64'(working), 64'd0);
        chk("rst2_valids",
            64'({bus.ld_ins_valid, bus.pe_ins_valid, bus.st_ins_valid}), 64'd0);
        chk("rst2_err", 64'(err_illegal), 64'd0);
        chk("rst2_conf", 64'(conf_in_img_width), 64'd0);
        cfg_ready("rst2_cfg_ready", 1'b1);
        @(negedge clk); bus.ins_valid = 1'b1; bus.ins = c0;
        @(negedge clk); bus.ins_valid = 1'b0; #1;
        chk("rst2_loaded_cleared", 64'(bus.pe_ins_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule

// File: doc/ins_dispatch_sb.md
INS_DISPATCH_SB -- requirements
Module: ins_dispatch_sb

Interface
REQ-001 SHALL have parameter INST_W, default 64, instruction width (>=64).
REQ-002 SHALL have parameter PE_NUM, default 32, width of pe_done.
REQ-003 SHALL have parameter Q_DEPTH, default 4, per-class queue depth (power of 2, >=2).
REQ-004 SHALL have parameter BUF_NUM, default 2, scoreboard slots (power of 2, 2..64).
REQ-005 SHALL have ports clk input 1 clock, and rst input 1 reset; single clock; reset synchronous, active-high.
REQ-006 SHALL have port ins_valid/ins_ready/ins input/output/input 1/1/INST_W: instruction stream, valid-ready.
REQ-007 SHALL have port ld_ins_valid/ld_ins_ready/ld_ins output/input/output 1/1/INST_W: load engine (ddr2pe) port.
REQ-008 SHALL have port pe_ins_valid/pe_ins_ready/pe_ins output/input/output 1/1/INST_W: compute engine port.
REQ-009 SHALL have port st_ins_valid/st_ins_ready/st_ins output/input/output 1/1/INST_W: store engine (pe2ddr) port.
REQ-010 SHALL have ports rx_done_pulse input 1, load complete, and rx_done_buf_id input 6, slot completed.
REQ-011 SHALL have port pe_done input PE_NUM: per-PE done level.
REQ-012 SHALL have conf outputs conf_layer_type 4, conf_in_ch_seg 4, conf_out_ch_seg 4, conf_in_img_width 8, conf_out_img_width 8, conf_pooling 1, conf_relu 1, conf_depool 1.
REQ-013 SHALL have outputs working 1, busy indicator, and err_illegal 1, sticky illegal-opcode flag.

Function
REQ-014 SHALL decode class from ins[INST_W-1:INST_W-4]: 0 config, 1 load, 2 compute, 3 store, 4..15 illegal.
REQ-015 SHALL take slot = ins[log2(BUF_NUM)-1:0] for load/compute; rx_done slot = rx_done_buf_id modulo BUF_NUM.
REQ-016 SHALL assert ins_ready combinationally: load/compute/store class -> matching queue not full; config -> all queues empty, outstanding=0, compute_busy=0; illegal -> 1.
REQ-017 SHALL push accepted load/compute/store instructions unmodified into their queue; head visible on *_ins_valid one cycle after acceptance, never same cycle.
REQ-018 SHALL, on accepted config, register on next edge: layer_type ins[59:56], in_ch_seg ins[55:52], out_ch_seg ins[51:48], in_img_width ins[47:40], out_img_width ins[39:32], pooling ins[2], relu ins[1], depool ins[0].
REQ-019 SHALL drop accepted illegal instructions and set err_illegal next cycle, held until rst.
REQ-020 SHALL present ld_ins_valid = load queue non-empty; on handshake pop and increment outstanding counter (width log2(Q_DEPTH*BUF_NUM)+1).
REQ-021 SHALL decrement outstanding on rx_done_pulse; load handshake plus pulse same cycle leaves it unchanged; pulse at outstanding=0 is ignored.
REQ-022 SHALL set loaded[slot] on rx_done_pulse (outstanding>0); already-set bit stays 1.
REQ-023 SHALL assert pe_ins_valid only when compute queue non-empty, loaded[head slot]=1, compute_busy=0.
REQ-024 SHALL, on pe handshake, pop, clear loaded[head slot], set compute_busy; if rx_done_pulse sets the same slot in that cycle, set wins.
REQ-025 SHALL clear compute_busy on the rising edge of AND(pe_done) (registered previous value), not on a level held from before issue.
REQ-026 SHALL assert st_ins_valid only when store queue non-empty, compute queue empty, compute_busy=0.
REQ-027 SHALL hold all *_ins outputs stable while valid and not ready.
REQ-028 SHALL drive working = any queue non-empty OR outstanding>0 OR compute_busy, registered.
REQ-029 SHALL accept simultaneous push and pop on a full queue only if pop is registered first: full queue -> ins_ready=0 regardless of same-cycle pop.
REQ-030 SHALL preserve per-class FIFO order; no reordering across classes other than REQ-023/026 gating.

Reset
REQ-031 SHALL on rst: empty all queues, outstanding=0, loaded all 0, compute_busy=0, err_illegal=0, working=0, all *_ins_valid=0, conf outputs 0, pe_done edge register=1.
REQ-032 SHALL, on rst mid-operation, discard queued instructions; ins_ready follows REQ-016 from the first cycle after rst deasserts.

Verification
REQ-033 SHALL cover: load slot1, compute slot1, no rx_done -> pe_ins_valid stays 0; rx_done_pulse id=1 -> pe_ins_valid=1 next cycle.
REQ-034 SHALL cover: compute issued, pe_done all-ones already high -> compute_busy stays 1 until pe_done drops and rises again.
REQ-035 SHALL cover: Q_DEPTH+1 loads, ld_ins_ready=0 -> ins_ready=0 at 5th (default), queue holds 4, order preserved on drain.
REQ-036 SHALL cover: config while store pending -> ins_ready=0; after store handshake and idle -> config accepted, conf_in_img_width=ins[47:40] next cycle.
REQ-037 SHALL cover: opcode 0x9 -> ins_ready=1, no output valid, err_illegal=1 next cycle, cleared only by rst.
REQ-038 SHALL cover: load handshake and rx_done_pulse same cycle with outstanding=1 -> outstanding stays 1; rst mid-stream -> working=0 and all valids 0 next cycle.
